// File: rtl/wb_led_sequencer.sv
// Autonomous Wishbone pipelined write master that refreshes the LED register every
// period_i cycles with a walking-one, binary-counter or static pattern.
module wb_led_sequencer #(
    parameter int unsigned               WB_BUS_WIDTH  = 16,
    parameter int unsigned               WB_ADDR_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0]  LED_ADDR      = 'h000000A0,
    parameter int unsigned               LED_WIDTH     = 16,
    parameter int unsigned               CNT_WIDTH     = 24,
    parameter int unsigned               TIMEOUT       = 15
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_reset_n_i,
    input  logic                         enable_i,
    input  logic [1:0]                   mode_i,
    input  logic [CNT_WIDTH-1:0]         period_i,
    input  logic [LED_WIDTH-1:0]         pattern_i,
    output logic [WB_ADDR_WIDTH-1:0]     wb_addr_o,
    output logic [WB_BUS_WIDTH-1:0]      wb_data_o,
    input  logic [WB_BUS_WIDTH-1:0]      wb_data_i,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    output logic                         wb_we_o,
    output logic [WB_BUS_WIDTH/8-1:0]    wb_sel_o,
    input  logic                         wb_ack_i,
    input  logic                         wb_stall_i,
    input  logic                         wb_err_i,
    input  logic                         wb_rty_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [7:0]                   err_cnt_o
);

    localparam int unsigned IDX_W  = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, REQ, WAIT_ACK} state_t;

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_pcnt;
    logic [TCNT_W-1:0]       r_tcnt;
    logic [IDX_W-1:0]        r_idx;
    logic [LED_WIDTH-1:0]    r_cnt;
    logic [1:0]              r_mode;
    logic [WB_BUS_WIDTH-1:0] r_data;
    logic                    r_cyc;
    logic                    r_stb;
    logic                    r_done;
    logic [7:0]              r_err_cnt;

    logic [CNT_WIDTH-1:0]    w_last;
    logic [LED_WIDTH-1:0]    w_pattern;
    logic                    w_live;
    logic                    w_term;
    logic                    w_timeout;
    state_t                  w_after;
    logic                    w_unused;

    assign w_last = (period_i == '0) ? '0 : period_i - CNT_WIDTH'(1);

    always_comb begin
        w_pattern = pattern_i;
        case (mode_i)
            2'd0:    w_pattern = LED_WIDTH'(1) << r_idx;
            2'd1:    w_pattern = r_cnt;
            default: w_pattern = pattern_i;
        endcase
    end

    // A termination counts in WAIT_ACK, or in REQ on the very cycle the request is accepted.
    assign w_live    = (r_state == WAIT_ACK) || ((r_state == REQ) && !wb_stall_i);
    assign w_term    = w_live && (wb_ack_i || wb_err_i || wb_rty_i);
    assign w_timeout = (r_tcnt == TCNT_W'(TIMEOUT - 1));
    assign w_after   = enable_i ? WAIT_TICK : IDLE;

    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            r_state   <= IDLE;
            r_pcnt    <= '0;
            r_tcnt    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_mode    <= '0;
            r_data    <= '0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_done    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pcnt <= '0;
                    if (enable_i) r_state <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (!enable_i) begin
                        r_pcnt  <= '0;
                        r_state <= IDLE;
                    end else if (r_pcnt == w_last) begin
                        r_pcnt  <= '0;
                        r_data  <= WB_BUS_WIDTH'(w_pattern);
                        r_mode  <= mode_i;
                        r_tcnt  <= '0;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= REQ;
                    end else begin
                        r_pcnt <= r_pcnt + CNT_WIDTH'(1);
                    end
                end
                REQ, WAIT_ACK: begin
                    if (w_term) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= w_after;
                        if (wb_ack_i) begin
                            r_done <= 1'b1;
                            if (r_mode == 2'd0)
                                r_idx <= (r_idx == IDX_W'(LED_WIDTH - 1)) ? '0 : r_idx + IDX_W'(1);
                            else if (r_mode == 2'd1)
                                r_cnt <= r_cnt + LED_WIDTH'(1);
                        end else if (wb_err_i && (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end else if (w_timeout) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= w_after;
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                        if ((r_state == REQ) && !wb_stall_i) begin
                            r_stb   <= 1'b0;
                            r_state <= WAIT_ACK;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_stb;
    assign wb_we_o   = r_cyc;
    assign wb_sel_o  = {(WB_BUS_WIDTH/8){r_cyc}};
    assign wb_addr_o = r_cyc ? LED_ADDR : '0;
    assign wb_data_o = r_data;
    assign busy_o    = (r_state == REQ) || (r_state == WAIT_ACK);
    assign done_o    = r_done;
    assign err_cnt_o = r_err_cnt;

    // Write-only master: read data is deliberately ignored.
    assign w_unused = ^wb_data_i;

endmodule
